// File: rtl/pri_decoder_2_4_if.sv
// Handshake bundle between the link driver and pri_decoder_2_4:
// (code, dis) transactions qualified by valid/ready.
interface pri_decoder_2_4_if;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_code;
    logic       in_dis;

    modport master (output in_valid, output in_code, output in_dis, input in_ready);
    modport slave  (input in_valid, input in_code, input in_dis, output in_ready);
endinterface

// File: rtl/pri_decoder_2_4.sv
// Receive end of the 4:1 priority-encoder link: buffers one (code, dis) entry and
// drives one decoded strobe line per entry. Optional macro: PRI_DEC_DIS_CNT_EN.
module pri_decoder_2_4 #(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned GAP_CYCLES  = 1,
    parameter int unsigned CNT_W       = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pri_decoder_2_4_if.slave     link,
    output logic [3:0]           out_line,
    output logic                 out_active,
    output logic                 busy
`ifdef PRI_DEC_DIS_CNT_EN
    ,
    output logic [CNT_W-1:0]     err_cnt
`endif
);

    // A hold of 0 is treated as 1, so both loads bottom out at 0.
    localparam logic [7:0] HOLD_LOAD = (HOLD_CYCLES == 0) ? 8'd0 : 8'(HOLD_CYCLES - 1);
    localparam logic [7:0] GAP_LOAD  = (GAP_CYCLES == 0)  ? 8'd0 : 8'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        GAP
    } state_t;

    state_t     state;
    logic [7:0] cnt;
    logic       buf_valid;
    logic [1:0] buf_code;
    logic       buf_dis;
    logic       pop;
    logic       push;

    assign pop           = (state == IDLE) && buf_valid;
    assign link.in_ready = rst_n && (!buf_valid || pop);
    assign push          = link.in_valid && link.in_ready;
    assign busy          = (state != IDLE) || buf_valid;

    // Unknown codes fall to the default arm, so the output is never X.
    function automatic logic [3:0] decode(input logic [1:0] code);
        logic [3:0] line;
        case (code)
            2'd1:    line = 4'b0010;
            2'd2:    line = 4'b0100;
            2'd3:    line = 4'b1000;
            default: line = 4'b0001;
        endcase
        return line;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            buf_valid  <= 1'b0;
            buf_code   <= '0;
            buf_dis    <= 1'b0;
            out_line   <= '0;
            out_active <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register reading the
            // pre-edge values, so pop and push in one cycle see a consistent buffer.
            if (push) begin
                buf_valid <= 1'b1;
                buf_code  <= link.in_code;
                buf_dis   <= link.in_dis;
            end else if (pop) begin
                buf_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (pop && !buf_dis) begin
                        state      <= HOLD;
                        out_line   <= decode(buf_code);
                        out_active <= 1'b1;
                        cnt        <= HOLD_LOAD;
                    end
                end
                HOLD: begin
                    if (cnt == 8'd0) begin
                        out_line   <= '0;
                        out_active <= 1'b0;
                        if (GAP_CYCLES == 0) begin
                            state <= IDLE;
                        end else begin
                            state <= GAP;
                            cnt   <= GAP_LOAD;
                        end
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                GAP: begin
                    if (cnt == 8'd0) state <= IDLE;
                    else             cnt   <= cnt - 8'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef PRI_DEC_DIS_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (pop && buf_dis && (err_cnt != '1)) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end
`endif

endmodule
